matvec_exec_seq: RTL and testbench
==================================

Name: matvec_exec_seq

Overview:
- Execution sequencer plus MAC lane array for the matrix-vector path.
- After the loader has filled N A-row FIFOs and one B FIFO, one start pulse does the following:
  - streams K elements from every FIFO;
  - multiply-accumulates the broadcast B element into N lanes;
  - flags the results valid.
- Replaces hand-sequenced rden/En/Clr driving. Adds empty-stall handling, multi-pass accumulation and a stall counter.

Parameters:
- DATA_WIDTH, 8, width of A and B elements.
- N, 8, number of A rows / MAC lanes.
- K, 8, elements consumed per FIFO per pass (K >= 1).
- ACC_WIDTH, 24, per-lane accumulator width (must be >= 2*DATA_WIDTH).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a pass; sampled only in IDLE
- accum  in  1  sampled with start: 1 = keep accumulators, 0 = clear them
- a_empty  in  N  per-lane A FIFO empty flags
- b_empty  in  1  B FIFO empty flag
- a_rdata  in  N*DATA_WIDTH  A FIFO outputs; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- b_rdata  in  DATA_WIDTH  B FIFO output
- a_rden  out  N  A FIFO read enables; all bits always equal
- b_rden  out  1  B FIFO read enable
- c_out  out  N*ACC_WIDTH  accumulators, lane i at bits [i*ACC_WIDTH +: ACC_WIDTH]
- busy  out  1  high from the cycle after start is accepted until DONE is exited
- done  out  1  one-cycle pulse when a pass completes
- c_valid  out  1  high from done until next accepted start or reset
- stall_cnt  out  16  cycles in RUN with a read wanted but blocked, current pass

Behaviour:
- Reset:
  - state IDLE.
  - All of the following are 0: c_out, busy, done, c_valid, stall_cnt, issue count, valid_q.
  - a_rden and b_rden are 0.
  - Reset mid-pass aborts immediately with the same values; no further rden issued.
- FIFO timing: o_data updates on the posedge where rden=1. Data read in cycle t is consumed at edge t+1 via the registered flag valid_q.
- States IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 at an edge: enter RUN, issue count := 0, stall_cnt := 0, c_valid := 0.
  - If accum=0, all accumulators := 0 at that edge; if accum=1 they are held.
- RUN:
  - fire = (issue count < K) & ~|a_empty & ~b_empty.
  - a_rden = {N{fire}}, b_rden = fire; combinational from state, count and flags.
  - On fire, issue count increments.
  - When issue count < K and fire=0, stall_cnt increments, saturating at 16'hFFFF.
  - Leave for DRAIN at the edge where issue count reaches K.
- valid_q <= fire every cycle; 0 outside RUN.
  - When valid_q=1: acc[i] <= acc[i] + a_rdata[i]*b_rdata.
  - Unsigned operands; the product is zero-extended.
  - Sum wraps modulo 2^ACC_WIDTH.
- DRAIN: one cycle, performs the final accumulate, then DONE.
- DONE: one cycle with done=1. Set c_valid=1; busy stays 1 this cycle; go to IDLE.
- Latency with no stalls:
  - start sampled at edge 0.
  - rden high cycles 1..K.
  - done high in cycle K+2.
  - Each stall cycle adds exactly 1.
- start while not IDLE is ignored, including the DONE cycle.
- accum is ignored except when start is accepted.
- c_out holds stable outside accumulate edges and reflects the live accumulators at all times.
- FIFOs becoming empty permanently hangs in RUN; no timeout here. Reset is the only exit.

Optional Feature:
- Macro: MATVEC_SAT_ACC_EN.
- Defined: each lane accumulation clamps to 2^ACC_WIDTH-1 instead of wrapping. Once saturated, a lane stays saturated until cleared.
- Undefined: modulo wrap as above. No saturation logic is synthesised.

Test Plan:
- Basic pass:
  - Stimulus: defaults; A lane i holds eight copies of (i+1); B holds 1..8; start with accum=0.
  - Response: c_out[0]=0x24, c_out[3]=0x90, c_out[7]=0x120.
  - done is a single pulse in cycle 10 after start; stall_cnt=0; c_valid=1.
- Accumulate:
  - Stimulus: refill the FIFOs identically and start with accum=1.
  - Response: c_out[0]=0x48, c_out[7]=0x240.
  - A third start with accum=0 on the same data returns c_out[0]=0x24.
- Stall:
  - Stimulus: force b_empty=1 for 3 cycles after the 4th read.
  - Response: no rden pulses during the stall; stall_cnt=3; done in cycle 13; results identical to the basic pass.
- Overflow:
  - Stimulus: ACC_WIDTH=16, all A and B = 0xFF, K=8.
  - Response: c_out lanes = 0xF008 without the macro; 0xFFFF with MATVEC_SAT_ACC_EN.
- Reset mid-run:
  - Stimulus: assert rst_n=0 after 3 reads.
  - Response: next cycle all outputs are 0 and state is IDLE.
  - A start pulse while busy is ignored (busy and issue count unaffected).
- K=1 corner:
  - Stimulus: one element per FIFO, A=3, B=5.
  - Response: c_out lanes = 15; done in cycle 3 after start.

Source files
------------

// File: rtl/matvec_exec_seq.sv
// matvec_exec_seq
//   Execution sequencer and MAC lane array for the matrix-vector path.
//   A single start pulse streams K elements out of N A-row FIFOs and one
//   B FIFO. The broadcast B element is multiply-accumulated into N lanes,
//   and the result is flagged valid when the pass completes. FIFO underrun
//   stalls issue; each blocked cycle is counted in o_stall_cnt.
//
//   Optional build macro: MATVEC_SAT_ACC_EN
//     When defined, lane accumulation clamps at all-ones instead of wrapping.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   i_start, i_accum    begin a pass (IDLE only); keep (1) / clear (0) accumulators
//   i_a_empty[N]        A FIFO empty flags
//   i_b_empty           B FIFO empty flag
//   i_a_rdata           A FIFO data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_b_rdata           B FIFO data
//   o_a_rden[N]         A FIFO read enables (all bits identical)
//   o_b_rden            B FIFO read enable
//   o_c_out             live accumulators, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   o_busy              pass in progress (RUN/DRAIN/DONE)
//   o_done              one-cycle pass-complete pulse
//   o_c_valid           results valid, from done until next accepted start
//   o_stall_cnt         blocked-read cycles in the current pass (saturating)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing FIFO reads, accumulating data read the cycle before
// DRAIN | final accumulate of the last element read
// DONE  | done pulse, results valid

module matvec_exec_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 8,
  parameter int K          = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic                    i_accum,
  input  logic [N-1:0]            i_a_empty,
  input  logic                    i_b_empty,
  input  logic [N*DATA_WIDTH-1:0] i_a_rdata,
  input  logic [DATA_WIDTH-1:0]   i_b_rdata,
  output logic [N-1:0]            o_a_rden,
  output logic                    o_b_rden,
  output logic [N*ACC_WIDTH-1:0]  o_c_out,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_c_valid,
  output logic [15:0]             o_stall_cnt
);

  localparam int CW = $clog2(K + 1);
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_issue;
  logic           r_valid_q;
  logic [15:0]    r_stall_cnt;
  logic           r_c_valid;
  logic           w_issue_lt_k;
  logic           w_fire;
  logic           w_last;
  logic           w_accept;
  logic           w_clear;

  always_comb begin
    w_state_nxt  = r_state;
    w_issue_lt_k = (r_issue < CW'(K));
    w_fire       = 1'b0;
    w_last       = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = i_start;
        if (i_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_fire = w_issue_lt_k & ~|i_a_empty & ~i_b_empty;
        // Leave RUN on the edge where the K-th read is issued.
        w_last = w_fire & (r_issue == CW'(K - 1));
        if (w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_clear     = w_accept & ~i_accum;
  assign o_a_rden    = {N{w_fire}};
  assign o_b_rden    = w_fire;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_c_valid   = r_c_valid;
  assign o_stall_cnt = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_issue     <= '0;
      r_valid_q   <= 1'b0;
      r_stall_cnt <= '0;
      r_c_valid   <= 1'b0;
    end else begin
      // Data read this cycle lands on the FIFO outputs at this edge and is
      // consumed one edge later.
      r_valid_q <= w_fire;
      if (w_accept) begin
        r_issue     <= '0;
        r_stall_cnt <= '0;
        r_c_valid   <= 1'b0;
      end else begin
        if (w_fire) r_issue <= r_issue + CW'(1);
        if ((r_state == S_RUN) && w_issue_lt_k && !w_fire && (r_stall_cnt != 16'hFFFF))
          r_stall_cnt <= r_stall_cnt + 16'd1;
        // Set on the DRAIN edge so c_valid rises together with done.
        if (r_state == S_DRAIN) r_c_valid <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [ACC_WIDTH-1:0] r_acc;
    logic [PW-1:0]        w_prod;
    logic [ACC_WIDTH-1:0] w_next;

    assign w_prod = PW'(i_a_rdata[g*DATA_WIDTH +: DATA_WIDTH]) * PW'(i_b_rdata);

`ifdef MATVEC_SAT_ACC_EN
    logic [ACC_WIDTH:0] w_sum;
    assign w_sum  = {1'b0, r_acc} + (ACC_WIDTH + 1)'(w_prod);
    // A clamped lane stays clamped: all-ones plus anything carries out again.
    assign w_next = w_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
    assign w_next = r_acc + ACC_WIDTH'(w_prod);
`endif

    always_ff @(posedge clk) begin
      if (!rst_n)         r_acc <= '0;
      else if (w_clear)   r_acc <= '0;
      else if (r_valid_q) r_acc <= w_next;
    end

    assign o_c_out[g*ACC_WIDTH +: ACC_WIDTH] = r_acc;
  end

endmodule

// File: tb/tb_matvec_exec_seq.sv
// Testbench for matvec_exec_seq: table of passes on the default build with a
// behavioural FIFO model and scoreboard, plus hand sequences for reset
// mid-pass, accumulator overflow (ACC_WIDTH=16) and the K=1 corner.

module tb_matvec_exec_seq;

  localparam int MN = 8;
  localparam int MK = 8;
`ifdef MATVEC_SAT_ACC_EN
  localparam logic [15:0] EXP_OVF = 16'hFFFF;
`else
  localparam logic [15:0] EXP_OVF = 16'hF008;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // main instance (defaults)
  logic              m_start, m_accum, m_b_empty;
  logic [MN-1:0]     m_a_empty, m_a_rden;
  logic [MN*8-1:0]   m_a_rdata;
  logic [7:0]        m_b_rdata;
  logic              m_b_rden, m_busy, m_done, m_c_valid;
  logic [MN*24-1:0]  m_c_out;
  logic [15:0]       m_stall;

  // overflow instance
  logic              v_start, v_accum, v_b_empty;
  logic [1:0]        v_a_empty, v_a_rden;
  logic [15:0]       v_a_rdata;
  logic [7:0]        v_b_rdata;
  logic              v_b_rden, v_busy, v_done, v_c_valid;
  logic [31:0]       v_c_out;
  logic [15:0]       v_stall;

  // K=1 instance
  logic              k_start, k_accum, k_b_empty;
  logic [1:0]        k_a_empty, k_a_rden;
  logic [15:0]       k_a_rdata;
  logic [7:0]        k_b_rdata;
  logic              k_b_rden, k_busy, k_done, k_c_valid;
  logic [47:0]       k_c_out;
  logic [15:0]       k_stall;

  matvec_exec_seq u_main (
    .clk(clk), .rst_n(rst_n), .i_start(m_start), .i_accum(m_accum),
    .i_a_empty(m_a_empty), .i_b_empty(m_b_empty), .i_a_rdata(m_a_rdata),
    .i_b_rdata(m_b_rdata), .o_a_rden(m_a_rden), .o_b_rden(m_b_rden),
    .o_c_out(m_c_out), .o_busy(m_busy), .o_done(m_done),
    .o_c_valid(m_c_valid), .o_stall_cnt(m_stall)
  );

  matvec_exec_seq #(.DATA_WIDTH(8), .N(2), .K(8), .ACC_WIDTH(16)) u_ovf (
    .clk(clk), .rst_n(rst_n), .i_start(v_start), .i_accum(v_accum),
    .i_a_empty(v_a_empty), .i_b_empty(v_b_empty), .i_a_rdata(v_a_rdata),
    .i_b_rdata(v_b_rdata), .o_a_rden(v_a_rden), .o_b_rden(v_b_rden),
    .o_c_out(v_c_out), .o_busy(v_busy), .o_done(v_done),
    .o_c_valid(v_c_valid), .o_stall_cnt(v_stall)
  );

  matvec_exec_seq #(.DATA_WIDTH(8), .N(2), .K(1), .ACC_WIDTH(24)) u_k1 (
    .clk(clk), .rst_n(rst_n), .i_start(k_start), .i_accum(k_accum),
    .i_a_empty(k_a_empty), .i_b_empty(k_b_empty), .i_a_rdata(k_a_rdata),
    .i_b_rdata(k_b_rdata), .o_a_rden(k_a_rden), .o_b_rden(k_b_rden),
    .o_c_out(k_c_out), .o_busy(k_busy), .o_done(k_done),
    .o_c_valid(k_c_valid), .o_stall_cnt(k_stall)
  );

  typedef struct {
    bit          accum;
    bit          stall;
    bit          rnd;
    bit          chk;
    logic [23:0] e0, e3, e7;
    int          lat;
    int          stl;
  } pass_t;

  pass_t             passes[6];
  logic [7:0]        aq[MN][$];
  logic [7:0]        bq[$];
  logic [MN*24-1:0]  sb[$];
  logic [23:0]       model[MN];
  bit                b_force;
  int                n_chk = 0;
  int                n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic update_empty();
    for (int i = 0; i < MN; i++) m_a_empty[i] = (aq[i].size() == 0);
    m_b_empty = (bq.size() == 0) || b_force;
  endtask

  task automatic fifo_pop();
    for (int i = 0; i < MN; i++)
      if (aq[i].size() > 0) m_a_rdata[i*8 +: 8] = aq[i].pop_front();
    if (bq.size() > 0) m_b_rdata = bq.pop_front();
  endtask

  task automatic fill(input bit rnd, input bit accum, input bit push);
    logic [7:0]       bv[MK];
    logic [7:0]       av;
    logic [MN*24-1:0] e;
    for (int j = 0; j < MK; j++) begin
      bv[j] = rnd ? 8'($urandom_range(0, 255)) : 8'(j + 1);
      bq.push_back(bv[j]);
    end
    for (int i = 0; i < MN; i++) begin
      if (!accum) model[i] = '0;
      for (int j = 0; j < MK; j++) begin
        av = rnd ? 8'($urandom_range(0, 255)) : 8'(i + 1);
        aq[i].push_back(av);
        model[i] = model[i] + 24'(16'(av) * 16'(bv[j]));
      end
      e[i*24 +: 24] = model[i];
    end
    if (push) sb.push_back(e);
    update_empty();
  endtask

  task automatic run_pass(input pass_t p, input int idx);
    bit               rd;
    bit               got;
    logic [MN*24-1:0] exp;
    fill(p.rnd, p.accum, 1'b1);
    m_accum = p.accum;
    m_start = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    m_accum = 1'b0;
    got = 1'b0;
    for (int e = 1; e <= 40 && !got; e++) begin
      @(negedge clk);
      rd = m_b_rden;
      chk("rden_equal", 256'(m_a_rden), 256'({MN{m_b_rden}}));
      if (e == 1) begin
        chk("busy_after_start", 256'(m_busy), 256'(1));
        chk("c_valid_cleared", 256'(m_c_valid), 256'(0));
      end
      if (p.stall && e >= 5 && e <= 7)
        chk("no_rden_in_stall", 256'({m_a_rden, m_b_rden}), 256'(0));
      if (m_done) begin
        got = 1'b1;
        chk("done_cycle", 256'(e), 256'(p.lat));
        chk("stall_cnt", 256'(m_stall), 256'(p.stl));
        chk("c_valid_at_done", 256'(m_c_valid), 256'(1));
        chk("busy_at_done", 256'(m_busy), 256'(1));
        if (sb.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL scoreboard_empty pass=%0d actual=done required=entry", idx);
        end else begin
          exp = sb.pop_front();
          chk("c_out_model", 256'(m_c_out), 256'(exp));
        end
        if (p.chk) begin
          chk("lane0", 256'(m_c_out[0*24 +: 24]), 256'(p.e0));
          chk("lane3", 256'(m_c_out[3*24 +: 24]), 256'(p.e3));
          chk("lane7", 256'(m_c_out[7*24 +: 24]), 256'(p.e7));
        end
      end else begin
        @(posedge clk); #1;
        if (rd) fifo_pop();
        if (p.stall && e == 4) b_force = 1'b1;
        if (p.stall && e == 7) b_force = 1'b0;
        update_empty();
      end
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL done_timeout pass=%0d actual=no_done required=done", idx);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_single_pulse", 256'(m_done), 256'(0));
    chk("busy_after_done", 256'(m_busy), 256'(0));
    chk("c_valid_held", 256'(m_c_valid), 256'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    passes[0] = '{accum:0, stall:0, rnd:0, chk:1, e0:24'h24, e3:24'h90,  e7:24'h120, lat:10, stl:0};
    passes[1] = '{accum:1, stall:0, rnd:0, chk:1, e0:24'h48, e3:24'h120, e7:24'h240, lat:10, stl:0};
    passes[2] = '{accum:0, stall:0, rnd:0, chk:1, e0:24'h24, e3:24'h90,  e7:24'h120, lat:10, stl:0};
    passes[3] = '{accum:0, stall:1, rnd:0, chk:1, e0:24'h24, e3:24'h90,  e7:24'h120, lat:13, stl:3};
    passes[4] = '{accum:1, stall:0, rnd:1, chk:0, e0:24'h0,  e3:24'h0,   e7:24'h0,   lat:10, stl:0};
    passes[5] = '{accum:0, stall:1, rnd:1, chk:0, e0:24'h0,  e3:24'h0,   e7:24'h0,   lat:13, stl:3};

    rst_n = 1'b0;
    m_start = 0; m_accum = 0; m_a_rdata = '0; m_b_rdata = '0; b_force = 0;
    for (int i = 0; i < MN; i++) model[i] = '0;
    update_empty();
    v_start = 0; v_accum = 0; v_a_empty = '0; v_b_empty = 0; v_a_rdata = '1; v_b_rdata = '1;
    k_start = 0; k_accum = 0; k_a_empty = '0; k_b_empty = 0;
    k_a_rdata = {8'd3, 8'd3}; k_b_rdata = 8'd5;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_c_out", 256'(m_c_out), 256'(0));
    chk("rst_flags", 256'({m_busy, m_done, m_c_valid}), 256'(0));
    chk("rst_stall", 256'(m_stall), 256'(0));
    chk("rst_rden", 256'({m_a_rden, m_b_rden}), 256'(0));
    chk("rst_ovf_rden", 256'({v_a_rden, v_b_rden, v_c_out}), 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) run_pass(passes[t], t);

    // Reset in the middle of a pass, with an ignored start while busy.
    fill(1'b0, 1'b0, 1'b0);
    m_start = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      if (e == 3) begin
        chk("busy_ignores_start", 256'(m_busy), 256'(1));
        chk("rden_ignores_start", 256'(m_b_rden), 256'(1));
      end
      @(posedge clk); #1;
      fifo_pop();
      update_empty();
      m_start = (e == 1);
    end
    m_start = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    fifo_pop();
    update_empty();
    @(negedge clk);
    chk("midrst_c_out", 256'(m_c_out), 256'(0));
    chk("midrst_flags", 256'({m_busy, m_done, m_c_valid}), 256'(0));
    chk("midrst_stall", 256'(m_stall), 256'(0));
    chk("midrst_rden", 256'({m_a_rden, m_b_rden}), 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < MN; i++) begin aq[i].delete(); model[i] = '0; end
    bq.delete();
    update_empty();
    @(negedge clk);
    chk("idle_after_rst", 256'({m_busy, m_a_rden, m_b_rden}), 256'(0));
    @(posedge clk); #1;

    // Overflow lanes, ACC_WIDTH=16.
    v_start = 1'b1;
    @(posedge clk); #1;
    v_start = 1'b0;
    begin
      bit got;
      got = 1'b0;
      for (int e = 1; e <= 40 && !got; e++) begin
        @(negedge clk);
        if (v_done) begin
          got = 1'b1;
          chk("ovf_done_cycle", 256'(e), 256'(10));
          chk("ovf_lane0", 256'(v_c_out[15:0]), 256'(EXP_OVF));
          chk("ovf_lane1", 256'(v_c_out[31:16]), 256'(EXP_OVF));
        end
      end
      if (!got) begin
        n_chk++; n_err++;
        $display("FAIL ovf_timeout actual=no_done required=done");
      end
    end
    @(posedge clk); #1;

    // K=1 corner.
    k_start = 1'b1;
    @(posedge clk); #1;
    k_start = 1'b0;
    begin
      bit got;
      got = 1'b0;
      for (int e = 1; e <= 20 && !got; e++) begin
        @(negedge clk);
        if (e == 1) chk("k1_rden", 256'({k_a_rden, k_b_rden}), 256'(7));
        if (e == 2) chk("k1_drain_no_rden", 256'({k_a_rden, k_b_rden}), 256'(0));
        if (k_done) begin
          got = 1'b1;
          chk("k1_done_cycle", 256'(e), 256'(3));
          chk("k1_lanes", 256'(k_c_out), 256'({24'd15, 24'd15}));
          chk("k1_c_valid", 256'(k_c_valid), 256'(1));
        end
      end
      if (!got) begin
        n_chk++; n_err++;
        $display("FAIL k1_timeout actual=no_done required=done");
      end
    end
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
